// File: rtl/pcap_packer_pkg.sv
// Shared types and constants for the position-capture sample packer.
package pcap_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PACK,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Bit positions inside irq_flags_o; bits 7:6 are reserved and read 0.
  localparam int FLG_BLOCK   = 0;
  localparam int FLG_DONE    = 1;
  localparam int FLG_OVERRUN = 2;
  localparam int FLG_OVFL    = 3;
  localparam int FLG_ABORT   = 4;
  localparam int FLG_NOMASK  = 5;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pcap_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a flush that empties it in one cycle.
module pcap_sync_fifo
  import pcap_packer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_push;
  logic          w_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty_o = (r_wr == r_rd);
  assign full_o  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = push_i & ~full_o & ~flush_i;
  assign w_pop   = pop_i & ~empty_o & ~flush_i;
  // Head word is forced to zero when empty so the output is clean out of reset.
  assign rdata_o = empty_o ? '0 : r_mem[r_rd[AW-1:0]];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= wdata_i;
  end

  // Read/write pointers; flush snaps the read pointer onto the write pointer.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush_i) begin
      r_rd <= r_wr;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/pcap_sample_packer.sv
// Captures NUM_CH channel words per trigger and serialises the masked ones to a DMA stream.
module pcap_sample_packer
  import pcap_packer_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DW      = 32,
  parameter int FIFO_AW = 10,
  parameter int CW      = 16
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               enable_i,
  input  logic               abort_i,
  input  logic               capture_i,
  input  logic [NUM_CH*DW-1:0] data_i,
  input  logic [NUM_CH-1:0]  mask_i,
  input  logic [CW-1:0]      block_size_i,
  output logic [DW-1:0]      dma_tdata_o,
  output logic               dma_tvalid_o,
  input  logic               dma_tready_i,
  output logic               armed_o,
  output logic               busy_o,
  output logic               irq_o,
  output logic [7:0]         irq_flags_o,
  output logic [CW-1:0]      smpl_count_o
);

  state_e                      r_state, w_nxt;
  logic                        r_en_d, r_ovr, r_stop, r_irq;
  logic [NUM_CH-1:0]           r_mask, r_rem;
  logic [NUM_CH-1:0][DW-1:0]   r_shadow;
  logic [7:0]                  r_flags;
  logic [CW-1:0]               r_cnt, r_blk;
  logic                        w_rise, w_fall, w_arm, w_cap, w_push, w_flush, w_pop;
  logic                        w_ovr, w_ovfl, w_done, w_abort, w_nomask, w_blk, w_stop_set;
  logic                        w_full, w_empty;
  logic [NUM_CH-1:0]           w_onehot, w_rem_nxt;
  logic [DW-1:0]               w_word;
  logic [7:0]                  w_ev;

  assign w_rise    = enable_i & ~r_en_d;
  assign w_fall    = ~enable_i & r_en_d;
  // Lowest pending channel, isolated as a one-hot; clearing it gives the next pending set.
  assign w_onehot  = r_rem & (~r_rem + NUM_CH'(1));
  assign w_rem_nxt = r_rem & ~w_onehot;
  assign w_pop     = dma_tvalid_o & dma_tready_i & ~w_flush;
  assign w_blk     = w_pop && (block_size_i != '0) && (r_blk + CW'(1) == block_size_i);

  // One-hot select of the shadow word to be written this cycle.
  always_comb begin
    w_word = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_onehot[c]) w_word = w_word | r_shadow[c];
  end

  // State register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= ST_IDLE;
    else           r_state <= w_nxt;
  end

  // Next-state and per-cycle event decode; abort overrides everything below it.
  always_comb begin
    w_nxt      = r_state;
    w_arm      = 1'b0;
    w_cap      = 1'b0;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    w_ovr      = 1'b0;
    w_ovfl     = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    w_nomask   = 1'b0;
    w_stop_set = 1'b0;
    case (r_state)
      ST_IDLE: if (w_rise) begin
        w_arm = 1'b1;
        if (mask_i == '0) begin
          w_nomask = 1'b1;
          w_nxt    = ST_DONE;
        end else begin
          w_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_fall) w_nxt = ST_DRAIN;
        else if (capture_i) begin
          w_cap = 1'b1;
          w_nxt = ST_PACK;
        end
      end
      ST_PACK: begin
        // A capture here is an overrun; only the first one raises the event.
        w_ovr      = capture_i & ~r_ovr;
        w_stop_set = w_fall;
        if (w_full) begin
          w_ovfl = 1'b1;
          w_nxt  = ST_DRAIN;
        end else begin
          w_push = 1'b1;
          if (w_rem_nxt == '0)
            w_nxt = (r_ovr | capture_i | r_stop | w_fall) ? ST_DRAIN : ST_ARMED;
        end
      end
      ST_DRAIN: if (w_empty) begin
        w_done = 1'b1;
        w_nxt  = ST_DONE;
      end
      ST_DONE: if (!enable_i) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
    if (abort_i && r_state != ST_IDLE) begin
      w_nxt      = ST_DONE;
      w_abort    = 1'b1;
      w_flush    = 1'b1;
      w_push     = 1'b0;
      w_cap      = 1'b0;
      w_ovr      = 1'b0;
      w_ovfl     = 1'b0;
      w_done     = 1'b0;
      w_stop_set = 1'b0;
    end
  end

  // Arm bookkeeping, sample counter and pending overrun/stop requests.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_en_d <= 1'b0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_ovr  <= 1'b0;
      r_stop <= 1'b0;
    end else begin
      r_en_d <= enable_i;
      if (w_arm) begin
        r_mask <= mask_i;
        r_cnt  <= '0;
        r_ovr  <= 1'b0;
        r_stop <= 1'b0;
      end else begin
        if (w_cap && r_cnt != '1) r_cnt <= r_cnt + CW'(1);
        r_ovr  <= r_ovr | w_ovr;
        r_stop <= r_stop | w_stop_set;
      end
    end
  end

  // Shadow snapshot on capture and the set of channels still to be sent.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_shadow <= '0;
      r_rem    <= '0;
    end else if (w_cap) begin
      r_shadow <= data_i;
      r_rem    <= r_mask;
    end else if (w_push) begin
      r_rem    <= w_rem_nxt;
    end
  end

  // Popped-word counter for the block interrupt.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)  r_blk <= '0;
    else if (w_arm) r_blk <= '0;
    else if (w_pop) r_blk <= w_blk ? '0 : r_blk + CW'(1);
  end

  // Collect all events of this cycle so simultaneous ones share one irq pulse.
  always_comb begin
    w_ev              = '0;
    w_ev[FLG_BLOCK]   = w_blk;
    w_ev[FLG_DONE]    = w_done | w_abort;
    w_ev[FLG_OVERRUN] = w_ovr;
    w_ev[FLG_OVFL]    = w_ovfl;
    w_ev[FLG_ABORT]   = w_abort;
    w_ev[FLG_NOMASK]  = w_nomask;
  end

  // Sticky flags (restarted at arm) and the one-cycle interrupt pulse.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_flags <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= w_arm ? w_ev : (r_flags | w_ev);
      r_irq   <= |w_ev;
    end
  end

  pcap_sync_fifo #(
    .DW    (DW),
    .DEPTH (1 << FIFO_AW)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .flush_i  (w_flush),
    .push_i   (w_push),
    .wdata_i  (w_word),
    .pop_i    (dma_tready_i),
    .rdata_o  (dma_tdata_o),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  assign dma_tvalid_o = ~w_empty;
  assign armed_o      = (r_state == ST_ARMED) || (r_state == ST_PACK);
  assign busy_o       = (r_state != ST_IDLE);
  assign irq_o        = r_irq;
  assign irq_flags_o  = r_flags;
  assign smpl_count_o = r_cnt;

endmodule

// File: tb/tb_pcap_sample_packer.sv
// Directed bench for pcap_sample_packer with a DMA word scoreboard.
module tb_pcap_sample_packer;

  localparam int NUM_CH = 8;
  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int CW     = 16;

  logic                   clk_i = 1'b0;
  logic                   resetn_i;
  logic                   enable_i, abort_i, capture_i, dma_tready_i;
  logic [NUM_CH*DW-1:0]   data_i;
  logic [NUM_CH-1:0]      mask_i;
  logic [CW-1:0]          block_size_i;
  logic [DW-1:0]          dma_tdata_o;
  logic                   dma_tvalid_o, armed_o, busy_o, irq_o;
  logic [7:0]             irq_flags_o;
  logic [CW-1:0]          smpl_count_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          irq_log[$];
  int          pop_cnt = 0;
  int          irq_cnt = 0;
  int          irq_base;
  bit          tog = 1'b0;

  always #5 clk_i = ~clk_i;

  pcap_sample_packer #(.NUM_CH(NUM_CH), .DW(DW), .FIFO_AW(AW), .CW(CW)) dut (
    .clk_i        (clk_i),
    .resetn_i     (resetn_i),
    .enable_i     (enable_i),
    .abort_i      (abort_i),
    .capture_i    (capture_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .block_size_i (block_size_i),
    .dma_tdata_o  (dma_tdata_o),
    .dma_tvalid_o (dma_tvalid_o),
    .dma_tready_i (dma_tready_i),
    .armed_o      (armed_o),
    .busy_o       (busy_o),
    .irq_o        (irq_o),
    .irq_flags_o  (irq_flags_o),
    .smpl_count_o (smpl_count_o)
  );

  function automatic logic [31:0] gen(input int n, input int c);
    return 32'h11 * 32'(c + 1) + 32'(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (tog) dma_tready_i = ~dma_tready_i;
    end
  endtask

  // Drive one capture strobe; optionally queue the words it should produce.
  task automatic cap(input int n, input logic [7:0] m, input bit expect_words);
    for (int c = 0; c < NUM_CH; c++) begin
      data_i[c*DW +: DW] = gen(n, c);
      if (expect_words && m[c]) exp_q.push_back(gen(n, c));
    end
    capture_i = 1'b1;
    tick(1);
    capture_i = 1'b0;
  endtask

  task automatic rearm(input logic [7:0] m);
    enable_i = 1'b0;
    tick(2);
    mask_i   = m;
    pop_cnt  = 0;
    irq_log.delete();
    enable_i = 1'b1;
    tick(1);
  endtask

  // Scoreboard side: compare every accepted DMA word and log irq pulses against pop count.
  always @(negedge clk_i) begin
    if (resetn_i) begin
      if (irq_o) begin
        irq_cnt++;
        irq_log.push_back(pop_cnt);
      end
      if (dma_tvalid_o && dma_tready_i && !abort_i) begin
        pop_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL dma_extra_word: observed=%0h expected=none", dma_tdata_o);
        end
        if (exp_q.size() != 0) check("dma_word", dma_tdata_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn_i = 1'b0; enable_i = 1'b0; abort_i = 1'b0; capture_i = 1'b0;
    dma_tready_i = 1'b1; data_i = '0; mask_i = '0; block_size_i = '0;
    tick(3);
    check("rst_tvalid", 32'(dma_tvalid_o), 0);
    check("rst_tdata",  dma_tdata_o, 0);
    check("rst_armed",  32'(armed_o), 0);
    check("rst_busy",   32'(busy_o), 0);
    check("rst_irq",    32'(irq_o), 0);
    check("rst_flags",  32'(irq_flags_o), 0);
    check("rst_count",  32'(smpl_count_o), 0);
    resetn_i = 1'b1;
    tick(2);

    // 1: sparse mask, three spaced captures, disarm
    rearm(8'h05);
    check("t1_armed", 32'(armed_o), 1);
    cap(0, 8'h05, 1);
    check("t1_lat_c1", 32'(dma_tvalid_o), 0);
    tick(1);
    check("t1_lat_c2", 32'(dma_tvalid_o), 1);
    check("t1_first",  dma_tdata_o, 32'h11);
    tick(8);
    cap(1, 8'h05, 1); tick(9);
    cap(2, 8'h05, 1); tick(9);
    check("t1_count", 32'(smpl_count_o), 3);
    check("t1_q_empty", 32'(exp_q.size()), 0);
    irq_base = irq_cnt;
    enable_i = 1'b0;
    tick(5);
    check("t1_flags", 32'(irq_flags_o), 32'h02);
    check("t1_irqs",  32'(irq_cnt - irq_base), 1);
    check("t1_idle",  32'(busy_o), 0);

    // 2: back-to-back captures -> overrun
    rearm(8'hFF);
    cap(0, 8'hFF, 1);
    cap(1, 8'hFF, 0);
    tick(15);
    check("t2_flags", 32'(irq_flags_o), 32'h06);
    check("t2_count", 32'(smpl_count_o), 1);
    check("t2_done_busy",  32'(busy_o), 1);
    check("t2_done_armed", 32'(armed_o), 0);
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // 3: FIFO overflow with stalled DMA
    dma_tready_i = 1'b0;
    rearm(8'hFF);
    cap(0, 8'hFF, 1); tick(11);
    cap(1, 8'hFF, 1); tick(11);
    cap(2, 8'hFF, 0); tick(4);
    check("t3_flags",  32'(irq_flags_o), 32'h08);
    check("t3_tvalid", 32'(dma_tvalid_o), 1);
    check("t3_head",   dma_tdata_o, gen(0, 0));
    tick(3);
    check("t3_stable", dma_tdata_o, gen(0, 0));
    check("t3_count",  32'(smpl_count_o), 3);
    dma_tready_i = 1'b1;
    tick(25);
    check("t3_flags_done", 32'(irq_flags_o), 32'h0A);
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // 4: block irq with throttled DMA
    block_size_i = 16'd4;
    rearm(8'h03);
    tog = 1'b1;
    for (int n = 0; n < 6; n++) begin
      cap(n, 8'h03, 1);
      tick(7);
    end
    tick(20);
    tog = 1'b0;
    dma_tready_i = 1'b1;
    check("t4_irq_n", 32'(irq_log.size()), 3);
    for (int i = 0; i < 3 && i < irq_log.size(); i++)
      check("t4_irq_at", 32'(irq_log[i]), 32'(4 * (i + 1)));
    check("t4_flags", 32'(irq_flags_o), 32'h01);
    check("t4_q_empty", 32'(exp_q.size()), 0);
    enable_i = 1'b0;
    tick(4);
    check("t4_flags_done", 32'(irq_flags_o), 32'h03);
    block_size_i = '0;

    // 5: abort mid-pack with 5 words queued
    dma_tready_i = 1'b0;
    rearm(8'hFF);
    cap(0, 8'hFF, 0);
    tick(5);
    check("t5_pre_tvalid", 32'(dma_tvalid_o), 1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    check("t5_tvalid", 32'(dma_tvalid_o), 0);
    check("t5_flags",  32'(irq_flags_o), 32'h12);
    check("t5_irq",    32'(irq_o), 1);
    tick(3);
    check("t5_busy", 32'(busy_o), 1);
    enable_i = 1'b0;
    tick(2);
    check("t5_idle", 32'(busy_o), 0);

    // 6: empty mask, then reset mid-pack
    dma_tready_i = 1'b1;
    rearm(8'h00);
    check("t6_flags", 32'(irq_flags_o), 32'h20);
    check("t6_irq",   32'(irq_o), 1);
    check("t6_armed", 32'(armed_o), 0);
    cap(0, 8'h00, 0);
    tick(1);
    check("t6_count", 32'(smpl_count_o), 0);
    check("t6_tvalid", 32'(dma_tvalid_o), 0);
    dma_tready_i = 1'b0;
    rearm(8'hFF);
    cap(5, 8'hFF, 0);
    tick(3);
    check("t6_pre_armed", 32'(armed_o), 1);
    resetn_i = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(dma_tvalid_o), 0);
    check("t6_rst_tdata",  dma_tdata_o, 0);
    check("t6_rst_armed",  32'(armed_o), 0);
    check("t6_rst_busy",   32'(busy_o), 0);
    check("t6_rst_flags",  32'(irq_flags_o), 0);
    check("t6_rst_count",  32'(smpl_count_o), 0);
    check("end_q_empty",   32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
